keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces presses and releases, and encodes the pressed key as a 4-bit code.
- Sits directly upstream of the keypad-input register stage that feeds the stopwatch/calculator mode logic and the operand reader.
- Emits one single-cycle strobe per accepted press and a level that stays high while the key is held.

Parameters:
- SCAN_DIV, 50000: clk cycles per row dwell period; one column sample is taken per period (minimum 4).
- DEBOUNCE_CNT, 4: consecutive consistent samples needed to accept a press, and separately to accept a release (minimum 2).
- REPEAT_DELAY, 40: samples held before the first auto-repeat strobe. Used only with the optional feature.
- REPEAT_RATE, 10: samples between subsequent auto-repeat strobes. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- line_n  out  4  row drive, one-hot active-low.
- column_n  in  4  column sense, active-low, asynchronous to clk.
- key_code  out  4  code of the last accepted key.
- key_strobe  out  1  one-cycle pulse when key_code is updated.
- key_held  out  1  high from acceptance until release is accepted.
- key_state  out  2  FSM state: 00 SCAN, 01 DEBOUNCE, 10 PRESSED, 11 RELEASE.

Behaviour:
- Reset (async, immediate):
  - line_n=4'b1110, key_code=0, key_strobe=0, key_held=0, key_state=SCAN.
  - Dwell counter, debounce counter and synchronizer flops all clear.
- Input synchronization: column_n passes through a 2-flop synchronizer. All decisions use the synchronized value (col_s).
- Sample instant: the cycle where the dwell counter equals SCAN_DIV-1. The counter then wraps to 0. Counting is free-running in every state.
- Key map (row r, lowest active column c):
  - Row 0: 1, 2, 3, 10
  - Row 1: 4, 5, 6, 11
  - Row 2: 7, 8, 9, 12
  - Row 3: 14, 0, 15, 13
  - Multiple columns low: the lowest column index wins.
- SCAN:
  - At each sample with col_s=4'hF, rotate line_n: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - At a sample with any col_s bit low: freeze line_n, latch candidate (row, col), set debounce count=1, go to DEBOUNCE.
- DEBOUNCE:
  - At each sample, if the lowest low column equals the candidate, increment the count. Otherwise go to SCAN; the row advances at the next sample.
  - When the count reaches DEBOUNCE_CNT:
    - next cycle: key_code=map(candidate), key_strobe=1 for exactly one cycle, key_held=1;
    - go to PRESSED.
- PRESSED:
  - line_n stays frozen.
  - A sample with the candidate column high: release count=1, go to RELEASE.
  - A different column going low while the candidate is still low is ignored. No rollover.
- RELEASE:
  - A sample with candidate column high increments the count.
  - A sample with candidate column low returns to PRESSED with no new strobe.
  - When the count reaches DEBOUNCE_CNT: key_held=0, go to SCAN, and the row rotates from the frozen row at the next sample.
- key_code holds its value through SCAN. Only acceptance changes it.
- Worst-case press latency: 4*SCAN_DIV + (DEBOUNCE_CNT-1)*SCAN_DIV + 3 cycles.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a sample counter starts at acceptance.
  - After REPEAT_DELAY samples, key_strobe pulses once (key_code unchanged), then again every REPEAT_RATE samples while in PRESSED.
  - Any entry into RELEASE restarts the delay.
- Undefined: exactly one strobe per press. The REPEAT_* parameters are ignored and the repeat counter is not synthesized.

Decomposition:
- Package keypad_pkg:
  - state encoding localparams SCAN/DEBOUNCE/PRESSED/RELEASE;
  - KEYMAP 4x4 constant of 4-bit codes;
  - named codes KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=13, KEY_STAR=14, KEY_HASH=15.
- Sub-module keypad_col_sync: 4-bit two-flop synchronizer with the same clk/rst; reset value 4'hF.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DELAY=4, REPEAT_RATE=2):
1. Assert rst mid-run -> line_n=1110, key_code=0, key_strobe=0, key_held=0, key_state=00 in the same cycle; rotation 1110, 1101, 1011, 0111 every 4 cycles after release.
2. Hold row1/col2 low when row1 is driven -> DEBOUNCE for 3 samples, then one-cycle key_strobe, key_code=6, key_held=1, state=10; no further strobe for 20 held samples.
3. Bounce: col0 low for exactly 1 sample on row3 -> returns to SCAN, no strobe, key_code unchanged, rotation resumes.
4. Release after test 2 -> col2 high for 3 samples drops key_held, state back to 00. A 1-sample high glitch inside PRESSED -> RELEASE, then back to PRESSED with no strobe.
5. Row0 with col0 and col3 both low -> key_code=1. Row3/col3 -> key_code=13. Row3/col0 -> key_code=14.
6. With KEYPAD_AUTOREPEAT_EN: hold key 5 -> strobes at acceptance, +4 samples, then every 2 samples. Without the macro -> single strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - state encodings, key codes and the row/column key map for the keypad scanner
package keypad_pkg;

    localparam logic [1:0] SCAN     = 2'b00;
    localparam logic [1:0] DEBOUNCE = 2'b01;
    localparam logic [1:0] PRESSED  = 2'b10;
    localparam logic [1:0] RELEASE  = 2'b11;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Indexed KEYMAP[row][col]; listed row 3 first and column 3 first within each row.
    localparam logic [3:0][3:0][3:0] KEYMAP = '{
        '{KEY_D, KEY_HASH, 4'd0, KEY_STAR},
        '{KEY_C, 4'd9,     4'd8, 4'd7    },
        '{KEY_B, 4'd6,     4'd5, 4'd4    },
        '{KEY_A, 4'd3,     4'd2, 4'd1    }
    };

    function automatic logic [1:0] lowest_low(input logic [3:0] col);
        if (!col[0])      return 2'd0;
        else if (!col[1]) return 2'd1;
        else if (!col[2]) return 2'd2;
        else              return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// rtl/keypad_col_sync.sv - two-flop synchronizer for the active-low column sense lines
module keypad_col_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] column_n,
    output logic [3:0] col_s
);

    logic [3:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 4'hF;
            col_s <= 4'hF;
        end else begin
            meta  <= column_n;
            col_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce and encode; KEYPAD_AUTOREPEAT_EN adds held-key repeat strobes
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 40,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] line_n,
    input  logic [3:0] column_n,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic       key_held,
    output logic [1:0] key_state
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_cnt;
    logic             sample;
    logic [1:0]       state, next_state;
    logic [1:0]       row, cand_col, low_col;
    logic [DEB_W-1:0] deb_cnt;
    logic             col_low, match, cand_high, deb_done;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;
`endif

    keypad_col_sync u_col_sync (
        .clk      (clk),
        .rst      (rst),
        .column_n (column_n),
        .col_s    (col_s)
    );

    assign sample    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign col_low   = (col_s != 4'hF);
    assign low_col   = lowest_low(col_s);
    assign match     = col_low && (low_col == cand_col);
    assign cand_high = col_s[cand_col];
    assign deb_done  = (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         div_cnt <= '0;
        else if (sample) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SCAN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (sample) begin
            case (state)
                SCAN:     if (col_low) next_state = DEBOUNCE;
                DEBOUNCE: if (!match) next_state = SCAN;
                          else if (deb_done) next_state = PRESSED;
                PRESSED:  if (cand_high) next_state = RELEASE;
                RELEASE:  if (!cand_high) next_state = PRESSED;
                          else if (deb_done) next_state = SCAN;
                default:  next_state = SCAN;
            endcase
        end
    end

    always_comb begin
        line_n    = ~(4'b0001 << row);
        key_state = state;
    end

    // The row only advances on an idle sample in SCAN, so it stays frozen on the candidate row elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row        <= 2'd0;
            cand_col   <= 2'd0;
            deb_cnt    <= '0;
            key_code   <= 4'd0;
            key_strobe <= 1'b0;
            key_held   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt    <= '0;
            rep_armed  <= 1'b0;
`endif
        end else begin
            key_strobe <= 1'b0;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (col_low) begin
                            cand_col <= low_col;
                            deb_cnt  <= DEB_W'(1);
                        end else begin
                            row <= row + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (match) begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                            if (deb_done) begin
                                key_code   <= KEYMAP[row][cand_col];
                                key_strobe <= 1'b1;
                                key_held   <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt    <= '0;
                                rep_armed  <= 1'b0;
`endif
                            end
                        end
                    end
                    PRESSED: begin
                        if (cand_high) begin
                            deb_cnt <= DEB_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt   <= '0;
                            rep_armed <= 1'b0;
                        end else if ((!rep_armed && rep_cnt == REP_W'(REPEAT_DELAY - 1)) ||
                                     ( rep_armed && rep_cnt == REP_W'(REPEAT_RATE - 1))) begin
                            key_strobe <= 1'b1;
                            rep_cnt    <= '0;
                            rep_armed  <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
`endif
                        end
                    end
                    RELEASE: begin
                        if (cand_high) begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                            if (deb_done) key_held <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner; honours KEYPAD_AUTOREPEAT_EN
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] line_n, column_n, key_code;
    logic       key_strobe, key_held;
    logic [1:0] key_state;
    logic [3:0] key_mask [4];

    always #5 clk = ~clk;

    // Physical matrix: a pressed switch pulls its column low only while its row is driven.
    assign column_n = ~((line_n[0] ? 4'h0 : key_mask[0]) | (line_n[1] ? 4'h0 : key_mask[1]) |
                        (line_n[2] ? 4'h0 : key_mask[2]) | (line_n[3] ? 4'h0 : key_mask[3]));

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_n     (line_n),
        .column_n   (column_n),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .key_held   (key_held),
        .key_state  (key_state)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_HOLD = 8;
    localparam int EXP_R1   = 1;
    localparam int EXP_R2   = 2;
`else
    localparam int EXP_HOLD = 0;
    localparam int EXP_R1   = 0;
    localparam int EXP_R2   = 0;
`endif

    typedef struct {
        int         row;
        logic [3:0] mask;
        logic [3:0] code;
    } vec_t;

    vec_t       vecs [9];
    logic [3:0] rot  [4];
    int         tests = 0;
    int         fails = 0;
    int         strobe_cnt = 0;
    int         s0;
    logic       prev_strobe = 1'b0;
    logic [3:0] exp_q [$];
    logic [3:0] last_code = 4'd0;
    logic [3:0] mon_exp;
    logic       found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_held(input logic lvl, input string name);
        int i;
        i = 0;
        while (key_held !== lvl && i < 100) begin
            step(1);
            i++;
        end
        check({name, " held"}, key_held, lvl);
    endtask

    task automatic press(input int r, input logic [3:0] m, input logic [3:0] code, input string name);
        key_mask[r] = m;
        exp_q.push_back(code);
        last_code = code;
        wait_held(1'b1, name);
        check({name, " state"}, key_state, 2'b10);
        check({name, " code"}, key_code, code);
    endtask

    task automatic release_key(input int r, input string name);
        key_mask[r] = 4'h0;
        wait_held(1'b0, name);
        check({name, " state"}, key_state, 2'b00);
    endtask

    // Scoreboard: each strobe pops the code queued at press time; a strobe with nothing queued is a repeat.
    always @(negedge clk) begin
        if (rst) begin
            prev_strobe = 1'b0;
        end else begin
            if (key_strobe) begin
                strobe_cnt++;
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("strobe code", key_code, mon_exp);
                end else begin
                    check("repeat code", key_code, last_code);
                end
                check("strobe single cycle", prev_strobe, 1'b0);
            end
            prev_strobe = key_strobe;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 4'b1001, 4'd1};
        vecs[1] = '{3, 4'b1000, 4'd13};
        vecs[2] = '{3, 4'b0001, 4'd14};
        vecs[3] = '{3, 4'b0010, 4'd0};
        vecs[4] = '{2, 4'b0100, 4'd9};
        vecs[5] = '{0, 4'b1000, 4'd10};
        vecs[6] = '{2, 4'b1000, 4'd12};
        vecs[7] = '{1, 4'b1000, 4'd11};
        vecs[8] = '{3, 4'b0100, 4'd15};
        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
        for (int r = 0; r < 4; r++) key_mask[r] = 4'h0;

        rst = 1'b1;
        step(3);
        check("rst line_n", line_n, 4'b1110);
        check("rst key_code", key_code, 4'd0);
        check("rst key_strobe", key_strobe, 1'b0);
        check("rst key_held", key_held, 1'b0);
        check("rst key_state", key_state, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Hold key 6 for 19 further samples
        press(1, 4'b0100, 4'd6, "key6");
        s0 = strobe_cnt;
        step(78);
        check("hold6 extra strobes", strobe_cnt - s0, EXP_HOLD);
        check("hold6 still held", key_held, 1'b1);
        release_key(1, "rel6");

        // One-sample high glitch while pressed
        press(1, 4'b0100, 4'd6, "key6b");
        s0 = strobe_cnt;
        key_mask[1] = 4'h0;
        step(4);
        check("glitch in RELEASE", key_state, 2'b11);
        key_mask[1] = 4'b0100;
        step(4);
        check("glitch back PRESSED", key_state, 2'b10);
        check("glitch held", key_held, 1'b1);
        check("glitch no strobe", strobe_cnt - s0, 0);
        release_key(1, "rel6b");

        // One-sample bounce on row 3 col 0
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (line_n == 4'b0111) found = 1'b1;
        end
        check("reach row3", line_n, 4'b0111);
        s0 = strobe_cnt;
        key_mask[3] = 4'b0001;
        step(4);
        check("bounce DEBOUNCE", key_state, 2'b01);
        key_mask[3] = 4'h0;
        step(4);
        check("bounce back SCAN", key_state, 2'b00);
        check("bounce row frozen", line_n, 4'b0111);
        step(4);
        check("bounce rotation", line_n, 4'b1110);
        check("bounce no strobe", strobe_cnt - s0, 0);
        check("bounce code kept", key_code, 4'd6);

        for (int i = 0; i < 9; i++) begin
            press(vecs[i].row, vecs[i].mask, vecs[i].code, $sformatf("vec%0d", i));
            release_key(vecs[i].row, $sformatf("vec%0d rel", i));
        end

        // Auto-repeat timing on key 5
        press(1, 4'b0010, 4'd5, "key5");
        s0 = strobe_cnt;
        step(15);
        check("key5 repeats @3 samples", strobe_cnt - s0, 0);
        step(2);
        check("key5 repeats @4 samples", strobe_cnt - s0, EXP_R1);
        step(8);
        check("key5 repeats @6 samples", strobe_cnt - s0, EXP_R2);
        release_key(1, "rel5");

        // Asynchronous reset mid-run with a key held
        press(0, 4'b0010, 4'd2, "key2");
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid rst line_n", line_n, 4'b1110);
        check("mid rst key_code", key_code, 4'd0);
        check("mid rst key_strobe", key_strobe, 1'b0);
        check("mid rst key_held", key_held, 1'b0);
        check("mid rst key_state", key_state, 2'b00);
        key_mask[0] = 4'h0;
        last_code = 4'd0;
        step(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step(1);
            check($sformatf("rotation k=%0d", k), line_n, rot[(k / 4) % 4]);
        end

        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
